// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: palette-driven colour sequencer feeding the RGB PWM duty inputs.
// Ramps each 8-bit channel one LSB per fade tick toward pal[idx], holds the colour
// for HOLD_TICKS ticks, then advances to the next entry up to last_idx.
// Optional feature macro: RGB_FADE_LOOP_EN (restart at entry 0 instead of finishing).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   wr_en/wr_addr/wr_data palette write port ({r,g,b})
//   last_idx             final palette entry of the sequence
//   start, stop          single-cycle start / abort requests
//   PWM_r/PWM_g/PWM_b    registered duty outputs
//   busy, idx, seq_done  status: not idle, active entry, end-of-sequence pulse
module rgb_fade_ctrl #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned HOLD_TICKS = 200,
   parameter int unsigned DEPTH      = 4,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   input  logic [AW-1:0] last_idx,
   input  logic          start,
   input  logic          stop,
   output logic [7:0]    PWM_r,
   output logic [7:0]    PWM_g,
   output logic [7:0]    PWM_b,
   output logic          busy,
   output logic [AW-1:0] idx,
   output logic          seq_done
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [AW-1:0] idx_d;
   logic [7:0]    r_d, g_d, b_d;
   logic          busy_d, done_d;
   logic          tick_c;
   logic [23:0]   tgt_c;
   logic [23:0]   pal [DEPTH];

   // One LSB toward the target; never overshoots, so no wrap at 0/255.
   function automatic logic [7:0] step(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)      return cur + 8'd1;
      else if (cur > tgt) return cur - 8'd1;
      else                return cur;
   endfunction

   // Palette storage; writes accepted in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) pal[i] <= '0;
      end else if (wr_en) begin
         pal[wr_addr] <= wr_data;
      end
   end

   assign tick_c = (state_q != IDLE) && (cnt_q == TW'(TICK_DIV - 1));
   // Target read live so a write to the active entry redirects the fade.
   assign tgt_c  = pal[idx];

   // Next-state and output computation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx;
      r_d     = PWM_r;
      g_d     = PWM_g;
      b_d     = PWM_b;
      hold_d  = hold_q;
      done_d  = 1'b0;
      if (state_q == IDLE || tick_c) cnt_d = '0;
      else                           cnt_d = cnt_q + TW'(1);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = FADE;
            end
         end
         FADE: begin
            if (tick_c) begin
               if ({PWM_r, PWM_g, PWM_b} == tgt_c) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end else begin
                  r_d = step(PWM_r, tgt_c[23:16]);
                  g_d = step(PWM_g, tgt_c[15:8]);
                  b_d = step(PWM_b, tgt_c[7:0]);
               end
            end
         end
         HOLD: begin
            if (tick_c) begin
               if (hold_q == HW'(HOLD_TICKS - 1)) begin
                  // last_idx below idx counts as end of sequence.
                  if (idx < last_idx) begin
                     idx_d   = idx + AW'(1);
                     state_d = FADE;
                  end else begin
`ifdef RGB_FADE_LOOP_EN
                     idx_d   = '0;
                     state_d = FADE;
`else
                     done_d  = 1'b1;
                     state_d = IDLE;
`endif
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything: freeze outputs, no completion pulse.
      if (stop) begin
         state_d = IDLE;
         idx_d   = idx;
         r_d     = PWM_r;
         g_d     = PWM_g;
         b_d     = PWM_b;
         hold_d  = hold_q;
         cnt_d   = '0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hold_q   <= '0;
         idx      <= '0;
         PWM_r    <= '0;
         PWM_g    <= '0;
         PWM_b    <= '0;
         busy     <= 1'b0;
         seq_done <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         idx      <= idx_d;
         PWM_r    <= r_d;
         PWM_g    <= g_d;
         PWM_b    <= b_d;
         busy     <= busy_d;
         seq_done <= done_d;
      end
   end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Scoreboard bench for rgb_fade_ctrl (TICK_DIV=4, HOLD_TICKS=2, DEPTH=4).
// Expected per-tick snapshots {r,g,b,busy,idx,seq_done} are queued when a
// sequence is started and compared on each tick edge.
module tb_rgb_fade_ctrl;

   localparam int unsigned TD = 4;
`ifdef RGB_FADE_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, wr_en, start, stop;
   logic [1:0] wr_addr, last_idx, idx;
   logic [23:0] wr_data;
   logic [7:0] PWM_r, PWM_g, PWM_b;
   logic       busy, seq_done;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          cyc = 0;
   int          next_tick = 0;
   logic [27:0] exp_q[$];
   string       tag_q[$];

   rgb_fade_ctrl #(.TICK_DIV(4), .HOLD_TICKS(2), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .last_idx(last_idx), .start(start), .stop(stop),
      .PWM_r(PWM_r), .PWM_g(PWM_g), .PWM_b(PWM_b),
      .busy(busy), .idx(idx), .seq_done(seq_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [27:0] obs, input logic [27:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] pack(input logic [23:0] rgb, input logic bsy,
                                        input logic [1:0] ix, input logic dn);
      return {rgb, bsy, ix, dn};
   endfunction

   function automatic logic [27:0] obs_now();
      return {PWM_r, PWM_g, PWM_b, busy, idx, seq_done};
   endfunction

   task automatic push(input string tag, input logic [23:0] rgb, input logic bsy,
                       input logic [1:0] ix, input logic dn);
      exp_q.push_back(pack(rgb, bsy, ix, dn));
      tag_q.push_back(tag);
   endtask

   // Pop and compare one entry per tick edge.
   task automatic run_ticks();
      logic [27:0] e;
      string       t;
      while (exp_q.size() > 0) begin
         while (cyc < next_tick) begin
            @(posedge clk); #1;
         end
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_val(t, obs_now(), e);
         next_tick += TD;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic write_pal(input logic [1:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      next_tick = cyc + TD;
      check_val("busy_rise", 28'(busy), 28'd1);
   endtask

   // Non-loop: completion pulse must drop; loop: stop freezes outputs.
   task automatic finish_seq(input logic [23:0] rgb, input logic [1:0] ix);
      if (LOOP) stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check_val("seq_end", obs_now(), pack(rgb, 1'b0, ix, 1'b0));
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      last_idx = '0; start = 1'b0; stop = 1'b0;
      do_reset();
      check_val("reset_state", obs_now(), pack(24'h0, 0, 0, 0));

      // Single fade to 0x030001.
      write_pal(0, 24'h030001);
      last_idx = 2'd0;
      pulse_start();
      push("A_t1", 24'h010001, 1, 0, 0);
      push("A_t2", 24'h020001, 1, 0, 0);
      push("A_t3", 24'h030001, 1, 0, 0);
      push("A_t4", 24'h030001, 1, 0, 0);
      push("A_t5", 24'h030001, 1, 0, 0);
      push("A_t6", 24'h030001, LOOP, 0, !LOOP);
      run_ticks();
      finish_seq(24'h030001, 0);

      // Down-ramp and advance to entry 1.
      do_reset();
      write_pal(0, 24'h020202);
      write_pal(1, 24'h000000);
      last_idx = 2'd1;
      pulse_start();
      push("B_t1", 24'h010101, 1, 0, 0);
      push("B_t2", 24'h020202, 1, 0, 0);
      push("B_t3", 24'h020202, 1, 0, 0);
      push("B_t4", 24'h020202, 1, 0, 0);
      push("B_t5", 24'h020202, 1, 1, 0);
      push("B_t6", 24'h010101, 1, 1, 0);
      push("B_t7", 24'h000000, 1, 1, 0);
      push("B_t8", 24'h000000, 1, 1, 0);
      push("B_t9", 24'h000000, 1, 1, 0);
      push("B_t10", 24'h000000, LOOP, LOOP ? 2'd0 : 2'd1, !LOOP);
      if (LOOP) push("B_t11", 24'h010101, 1, 0, 0);
      run_ticks();
      finish_seq(LOOP ? 24'h010101 : 24'h000000, LOOP ? 2'd0 : 2'd1);

      // Live write redirects the fade in progress.
      do_reset();
      write_pal(0, 24'h0A0000);
      last_idx = 2'd0;
      pulse_start();
      push("C_t1", 24'h010000, 1, 0, 0);
      push("C_t2", 24'h020000, 1, 0, 0);
      push("C_t3", 24'h030000, 1, 0, 0);
      push("C_t4", 24'h040000, 1, 0, 0);
      run_ticks();
      write_pal(0, 24'h020000);
      push("C_t5", 24'h030000, 1, 0, 0);
      push("C_t6", 24'h020000, 1, 0, 0);
      push("C_t7", 24'h020000, 1, 0, 0);
      push("C_t8", 24'h020000, 1, 0, 0);
      push("C_t9", 24'h020000, LOOP, 0, !LOOP);
      run_ticks();
      finish_seq(24'h020000, 0);

      // Asynchronous reset mid-FADE, then palette must read as zero.
      do_reset();
      write_pal(0, 24'h0A0000);
      last_idx = 2'd0;
      pulse_start();
      push("R_t1", 24'h010000, 1, 0, 0);
      push("R_t2", 24'h020000, 1, 0, 0);
      run_ticks();
      #3 rst_n = 1'b0;
      #1 check_val("async_rst", obs_now(), pack(24'h0, 0, 0, 0));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      push("Z_t1", 24'h000000, 1, 0, 0);
      push("Z_t2", 24'h000000, 1, 0, 0);
      push("Z_t3", 24'h000000, LOOP, 0, !LOOP);
      run_ticks();
      finish_seq(24'h000000, 0);

      // start and stop together: stop wins.
      do_reset();
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      check_val("start_stop", obs_now(), pack(24'h0, 0, 0, 0));
      repeat (6) @(posedge clk);
      #1 check_val("still_idle", obs_now(), pack(24'h0, 0, 0, 0));

      // start while busy is ignored (a restart would shift the tick phase).
      write_pal(0, 24'h030001);
      last_idx = 2'd0;
      pulse_start();
      push("D_t1", 24'h010001, 1, 0, 0);
      push("D_t2", 24'h020001, 1, 0, 0);
      run_ticks();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      push("D_t3", 24'h030001, 1, 0, 0);
      push("D_t4", 24'h030001, 1, 0, 0);
      push("D_t5", 24'h030001, 1, 0, 0);
      push("D_t6", 24'h030001, LOOP, 0, !LOOP);
      run_ticks();
      finish_seq(24'h030001, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
